// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter granting two requesters access to one external stack.
// Full/empty rejections are answered without touching the stack; pops wait POP_LAT cycles for read data.
module stack_arbiter #(
    parameter int WIDTH   = 16,
    parameter int POP_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             op0,
    input  logic             op1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             done0,
    output logic             done1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             busy,
    output logic             stk_enable,
    output logic             stk_operation,
    output logic [WIDTH-1:0] stk_data_in,
    input  logic [WIDTH-1:0] stk_data_out,
    input  logic             stk_full,
    input  logic             stk_empty
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic             win_q, win_d, last_q, last_d, op_q, op_d, err_q, err_d;
    logic [WIDTH-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             win, win_op, last_wait;

    // last_q names the requester granted most recently; a tie goes to the other one
    assign win       = (req0 && req1) ? ~last_q : req1;
    assign win_op    = win ? op1 : op0;
    assign last_wait = cnt_q == 2'(POP_LAT - 1);

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        op_d     = op_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (req0 || req1) begin
                win_d   = win;
                op_d    = win_op;
                wdata_d = win ? wdata1 : wdata0;
                err_d   = win_op ? stk_full : stk_empty;
                state_d = err_d ? DONE : ISSUE;
            end
            ISSUE: state_d = op_q ? DONE : WAIT;
            WAIT: begin
                cnt_d = cnt_q + 2'd1;
                if (last_wait) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    rdata0_d = win_q ? rdata0_q : stk_data_out;
                    rdata1_d = win_q ? stk_data_out : rdata1_q;
                end
            end
            DONE: begin
                last_d  = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            last_q   <= 1'b1;
            op_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            op_q     <= op_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy          = state_q != IDLE;
    assign stk_enable    = state_q == ISSUE;
    assign stk_operation = op_q;
    assign stk_data_in   = wdata_q;
    assign done0         = state_q == DONE && !win_q;
    assign done1         = state_q == DONE && win_q;
    assign err0          = done0 && err_q;
    assign err1          = done1 && err_q;
    assign rdata0        = rdata0_q;
    assign rdata1        = rdata1_q;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed vector table, tie/reset sequences and a randomized run
// against a transaction-level model with its own stack queue.
module tb_stack_arbiter;
    localparam int W = 16, PL = 1, DEPTH = 4;

    logic         clk = 1'b0, rst = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [W-1:0] wdata0 = '0, wdata1 = '0;
    logic         done0, done1, err0, err1, busy, stk_enable, stk_operation, stk_full, stk_empty;
    logic [W-1:0] rdata0, rdata1, stk_data_in, stk_data_out;
    logic [W-1:0] mem [DEPTH];
    int           sz = 0;
    int           checks = 0, errors = 0;

    typedef struct {
        bit           who;
        bit           op;
        logic [W-1:0] wd;
        bit           err;
        int           lat;
        logic [W-1:0] rd;
    } vec_t;
    vec_t tbl [13];

    always #5 clk = ~clk;

    stack_arbiter #(.WIDTH(W), .POP_LAT(PL)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .stk_enable(stk_enable), .stk_operation(stk_operation),
        .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
        .stk_full(stk_full), .stk_empty(stk_empty)
    );

    // external stack: popped word valid only in the cycle after the enable edge, noise otherwise
    assign stk_full  = sz == DEPTH;
    assign stk_empty = sz == 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sz <= 0;
            stk_data_out <= '0;
        end else begin
            stk_data_out <= W'($urandom);
            if (stk_enable && stk_operation && sz < DEPTH) begin
                mem[sz] <= stk_data_in;
                sz <= sz + 1;
            end
            if (stk_enable && !stk_operation && sz > 0) begin
                stk_data_out <= mem[sz-1];
                sz <= sz - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        req0 = 1'b0;
        req1 = 1'b0;
        rst  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int lat = 0, en = 0;
        bit other = 1'b0, got_err = 1'b0;
        if (v.who) begin req1 = 1'b1; op1 = v.op; wdata1 = v.wd; end
        else       begin req0 = 1'b1; op0 = v.op; wdata0 = v.wd; end
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (stk_enable) begin
                en++;
                chk($sformatf("v%0d stk_operation", idx), 32'(stk_operation), 32'(v.op));
                if (v.op) chk($sformatf("v%0d stk_data_in", idx), 32'(stk_data_in), 32'(v.wd));
            end
            if (v.who ? done0 : done1) other = 1'b1;
            if (v.who ? done1 : done0) begin
                lat = k;
                got_err = v.who ? err1 : err0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d err", idx), 32'(got_err), 32'(v.err));
        chk($sformatf("v%0d enable pulses", idx), 32'(en), v.err ? 32'd0 : 32'd1);
        chk($sformatf("v%0d other done", idx), 32'(other), 32'd0);
        chk($sformatf("v%0d rdata", idx), 32'(v.who ? rdata1 : rdata0), 32'(v.rd));
        @(posedge clk);
        #1;
    endtask

    task automatic tie_test();
        int k = 0;
        reset_dut();
        req0 = 1'b1; op0 = 1'b1; wdata0 = 16'hAAAA;
        req1 = 1'b1; op1 = 1'b1; wdata1 = 16'h5555;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(posedge clk);
            #1;
            if (done0 || done1) begin
                chk($sformatf("tie grant %0d", k), 32'({done1, done0}), (k % 2 == 1) ? 32'd2 : 32'd1);
                chk($sformatf("tie err %0d", k), 32'({err1, err0}), 32'd0);
                k++;
                if (k == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        chk("tie done count", 32'(k), 32'd4);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_in_wait_test();
        bit seen = 1'b0;
        reset_dut();
        run_txn('{1'b1, 1'b1, 16'hBEEF, 1'b0, 2, 16'h0000}, 20);
        req0 = 1'b1; op0 = 1'b0; wdata0 = 16'h00C3;
        @(posedge clk);
        #1;
        chk("rw issue enable", 32'(stk_enable), 32'd1);
        @(posedge clk);
        #1;
        chk("rw wait busy", 32'(busy), 32'd1);
        rst  = 1'b0;
        req0 = 1'b0;
        #1;
        chk("rw async busy", 32'(busy), 32'd0);
        chk("rw async done", 32'({done1, done0}), 32'd0);
        chk("rw async enable", 32'(stk_enable), 32'd0);
        chk("rw async data_in", 32'(stk_data_in), 32'd0);
        chk("rw async rdata0", 32'(rdata0), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done0 || done1) seen = 1'b1;
        end
        chk("rw no done in reset", 32'(seen), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        run_txn('{1'b0, 1'b1, 16'h0077, 1'b0, 2, 16'h0000}, 21);
    endtask

    task automatic random_test();
        bit           rq [2] = '{1'b0, 1'b0};
        bit           op [2] = '{1'b0, 1'b0};
        logic [W-1:0] wd [2] = '{'0, '0};
        logic [W-1:0] mrd [2] = '{'0, '0};
        logic [W-1:0] mq [$];
        logic [W-1:0] ev_data = '0;
        int           free_at = 0, arb_c = -1, ev_c = -1;
        bit           ev_who = 1'b0, ev_err = 1'b0, ev_pop = 1'b0, mlast = 1'b1, w, exp_d;
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            exp_d = c == ev_c;
            if (exp_d && ev_pop && !ev_err) mrd[ev_who] = ev_data;
            chk($sformatf("rnd c%0d done", c), 32'({done1, done0}), exp_d ? (ev_who ? 32'd2 : 32'd1) : 32'd0);
            chk($sformatf("rnd c%0d err", c), 32'({err1, err0}), (exp_d && ev_err) ? (ev_who ? 32'd2 : 32'd1) : 32'd0);
            chk($sformatf("rnd c%0d rdata0", c), 32'(rdata0), 32'(mrd[0]));
            chk($sformatf("rnd c%0d rdata1", c), 32'(rdata1), 32'(mrd[1]));
            chk($sformatf("rnd c%0d busy", c), 32'(busy), 32'(c > arb_c && c <= ev_c));
            for (int n = 0; n < 2; n++) begin
                if (rq[n] && (n == 1 ? done1 : done0)) rq[n] = $urandom_range(0, 1) == 1;
                else if (!rq[n] && $urandom_range(0, 2) == 0) begin
                    rq[n] = 1'b1;
                    op[n] = $urandom_range(0, 1) == 1;
                    wd[n] = W'($urandom);
                end
            end
            if (c >= free_at && (rq[0] || rq[1])) begin
                w      = (rq[0] && rq[1]) ? !mlast : rq[1];
                ev_err = op[w] ? mq.size() == DEPTH : mq.size() == 0;
                ev_pop = !op[w];
                if (!ev_err && op[w]) mq.push_back(wd[w]);
                if (!ev_err && !op[w]) ev_data = mq.pop_back();
                ev_c    = c + (ev_err ? 1 : op[w] ? 2 : 2 + PL);
                arb_c   = c;
                free_at = ev_c + 1;
                ev_who  = w;
                mlast   = w;
            end
            req0 = rq[0]; op0 = op[0]; wdata0 = wd[0];
            req1 = rq[1]; op1 = op[1]; wdata1 = wd[1];
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        tbl = '{
            '{1'b0, 1'b1, 16'h1234, 1'b0, 2, 16'h0000},
            '{1'b1, 1'b0, 16'h0000, 1'b0, 3, 16'h1234},
            '{1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0000},
            '{1'b1, 1'b1, 16'h0011, 1'b0, 2, 16'h1234},
            '{1'b1, 1'b1, 16'h0022, 1'b0, 2, 16'h1234},
            '{1'b1, 1'b1, 16'h0033, 1'b0, 2, 16'h1234},
            '{1'b1, 1'b1, 16'h0044, 1'b0, 2, 16'h1234},
            '{1'b0, 1'b1, 16'h0055, 1'b1, 1, 16'h0000},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 3, 16'h0044},
            '{1'b1, 1'b0, 16'h0000, 1'b0, 3, 16'h0033},
            '{1'b1, 1'b0, 16'h0000, 1'b0, 3, 16'h0022},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 3, 16'h0011},
            '{1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0011}
        };
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset enable", 32'(stk_enable), 32'd0);
        chk("reset done", 32'({done1, done0}), 32'd0);
        chk("reset err", 32'({err1, err0}), 32'd0);
        chk("reset rdata", 32'({rdata1, rdata0}), 32'd0);
        chk("reset stk_data_in", 32'(stk_data_in), 32'd0);
        chk("reset stk_operation", 32'(stk_operation), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) run_txn(tbl[i], i);
        tie_test();
        reset_in_wait_test();
        random_test();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data word width of the stack and both requester ports.
REQ-002 Parameter POP_LAT, default 1, range 1-4, cycles from the stack enable edge until stack data_out holds the popped word.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 req0/req1  input  1 each  requester n transaction request, level, held until done_n.
REQ-006 op0/op1  input  1 each  requester n operation, 1 = push, 0 = pop; stable while req_n high.
REQ-007 wdata0/wdata1  input  WIDTH each  requester n push data; stable while req_n high.
REQ-008 done0/done1  output  1 each  one-cycle completion pulse to requester n.
REQ-009 err0/err1  output  1 each  valid with done_n; 1 = rejected (push on full, pop on empty).
REQ-010 rdata0/rdata1  output  WIDTH each  popped word, valid with done_n on a successful pop.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 stk_enable  output  1  stack enable, one-cycle pulse per granted access.
REQ-013 stk_operation  output  1  stack operation, 1 = push, 0 = pop; meaningful while stk_enable high.
REQ-014 stk_data_in  output  WIDTH  push data to stack.
REQ-015 stk_data_out  input  WIDTH  stack read data.
REQ-016 stk_full/stk_empty  input  1 each  stack status flags.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, DONE; exactly one active.
REQ-018 IDLE: if neither request is high, the FSM stays in IDLE; otherwise it selects a winner, latches the winner's op and wdata, and goes to ISSUE or DONE on the next edge.
REQ-019 Arbitration round-robin: one request high -> that requester wins; both high -> the requester not granted last wins; last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-020 Rejection is decided in IDLE from stk_full/stk_empty in that cycle: push while full, or pop while empty, goes directly to DONE with err set and no stk_enable pulse.
REQ-021 ISSUE lasts one cycle: stk_enable=1, stk_operation=latched op, stk_data_in=latched wdata.
REQ-022 ISSUE exit: push -> DONE; pop -> WAIT.
REQ-023 WAIT lasts POP_LAT cycles via counter; on the last WAIT cycle stk_data_out is captured into the winner's rdata register.
REQ-024 DONE lasts one cycle: done_n=1 for the winner only, err_n as decided, last-grant pointer updated to the winner; next state is IDLE.
REQ-025 Latency, request seen in IDLE cycle T: push done at T+2; pop done at T+2+POP_LAT; reject done at T+1.
REQ-026 In the cycle after DONE the requester may drop or keep req; a held req starts a new arbitration in that IDLE cycle, so back-to-back transactions have one IDLE cycle between them.
REQ-027 Requests arriving while busy are not granted until IDLE; the loser of a tie keeps its req and wins the next arbitration.
REQ-028 rdata_n holds its last captured value until that requester's next successful pop; it is unchanged on pushes and rejects.
REQ-029 stk_enable is 0 in every state other than ISSUE; stk_data_in and stk_operation hold the latched values otherwise.
REQ-030 Dropping req_n before done_n does not abort the access; done_n still pulses.

Reset
REQ-031 Asserting rst low immediately, independent of clk: FSM to IDLE, stk_enable=0, done0/done1=0, err0/err1=0, busy=0, WAIT counter=0, last-grant pointer=1.
REQ-032 Reset values: rdata0/rdata1=0, stk_data_in=0, stk_operation=0.
REQ-033 Reset mid-transaction abandons it with no done pulse; if reset falls during ISSUE, stk_enable drops asynchronously.
REQ-034 First arbitration occurs in the first IDLE cycle after rst is released high.

Verification
REQ-035 Reset, req0=1 op0=1 wdata0=0x1234, stack empty -> stk_enable pulse with stk_operation=1 and stk_data_in=0x1234 one cycle later, done0=1 and err0=0 two cycles after the request.
REQ-036 After that push, req1=1 op1=0, POP_LAT=1 -> done1 three cycles after the request, rdata1=0x1234, err1=0.
REQ-037 req0 and req1 both held with pushes 0xAAAA and 0x5555 -> grant order 0,1,0,1 with alternating done0/done1 pulses.
REQ-038 stk_empty=1 with a pop request, or stk_full=1 with a push request -> done and err pulse one cycle after the request, with no stk_enable pulse.
REQ-039 rst driven low during WAIT -> outputs at reset values immediately, no done pulse; after release, a new req0 push completes normally.
